// File: rtl/slave_bridge_burst_tg_if.sv
// AXI4 bus bundle between the burst traffic generator (master) and the slave bridge.
interface slave_bridge_burst_tg_if #(
    parameter int DATA_WIDTH = 512,
    parameter int ADDR_WIDTH = 64
);
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [7:0]              awlen;
    logic [2:0]              awsize;
    logic [1:0]              awburst;
    logic [1:0]              awid;
    logic                    awlock;
    logic [3:0]              awcache;
    logic [2:0]              awprot;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wlast;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic [1:0]              bid;
    logic                    bvalid;
    logic                    bready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [7:0]              arlen;
    logic [2:0]              arsize;
    logic [1:0]              arburst;
    logic [1:0]              arid;
    logic                    arlock;
    logic [3:0]              arcache;
    logic [2:0]              arprot;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic [1:0]              rid;
    logic                    rlast;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awaddr, awlen, awsize, awburst, awid, awlock, awcache, awprot, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bresp, bid, bvalid,
        output bready,
        output araddr, arlen, arsize, arburst, arid, arlock, arcache, arprot, arvalid,
        input  arready,
        input  rdata, rresp, rid, rlast, rvalid,
        output rready
    );

    modport slave (
        input  awaddr, awlen, awsize, awburst, awid, awlock, awcache, awprot, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bresp, bid, bvalid,
        input  bready,
        input  araddr, arlen, arsize, arburst, arid, arlock, arcache, arprot, arvalid,
        output arready,
        output rdata, rresp, rid, rlast, rvalid,
        input  rready
    );
endinterface

// File: rtl/slave_bridge_burst_tg.sv
// AXI4 INCR-burst traffic generator for exercising the slave bridge path.
// Define RDATA_CHECK_EN to compare every read beat against the write pattern.
module slave_bridge_burst_tg #(
    parameter int                    TCQ             = 1,
    parameter int                    DATA_WIDTH      = 512,
    parameter int                    ADDR_WIDTH      = 64,
    parameter logic [ADDR_WIDTH-1:0] AXIBAR_ADDR     = 'h0,
    parameter int                    ADDR_RANGE      = 'h4000,
    parameter int                    BURST_LEN       = 4,
    parameter int                    MAX_OUTSTANDING = 8,
    parameter logic [31:0]           PATTERN_SEED    = 32'hA5A5_0000
) (
    input  logic                    fabric_clk,
    input  logic                    fabric_rst_n,
    input  logic                    gen_wr,
    input  logic                    gen_rd,
    output logic                    wr_req_rdy,
    output logic                    rd_req_rdy,
    slave_bridge_burst_tg_if.master m_axi,
    output logic [31:0]             wr_done_cnt,
    output logic [31:0]             rd_done_cnt,
    output logic [15:0]             err_cnt,
    output logic                    busy
);
    localparam int DATA_BYTES = DATA_WIDTH / 8;
    localparam int LANES      = DATA_WIDTH / 32;
    localparam int OFF_W      = $clog2(ADDR_RANGE);
    localparam int OUT_W      = $clog2(MAX_OUTSTANDING + 1);
    localparam int BEAT_W     = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [OFF_W-1:0]  BURST_STEP = OFF_W'(BURST_LEN * DATA_BYTES);
    localparam logic [OFF_W-1:0]  BEAT_STEP  = OFF_W'(DATA_BYTES);
    localparam logic [BEAT_W-1:0] LAST_BEAT  = BEAT_W'(BURST_LEN - 1);
    localparam logic [OUT_W-1:0]  OUT_MAX    = OUT_W'(MAX_OUTSTANDING);

    logic [1:0]       gen_req, addr_ready, done_evt;
    logic [1:0]       avalid, a_hs, q_full, q_nz, out_nz;
    logic [OFF_W-1:0] off_v [2];
    logic             r_last_evt, w_hs, w_last_hs;

    assign r_last_evt = m_axi.rvalid & m_axi.rlast;
    assign gen_req    = {gen_rd, gen_wr};
    assign addr_ready = {m_axi.arready, m_axi.awready};
    assign done_evt   = {r_last_evt, m_axi.bvalid};

    // Index 0 is the write direction (AW/B), index 1 the read direction (AR/R-last).
    for (genvar gi = 0; gi < 2; gi++) begin : g_dir
        logic [3:0]       q_reg;
        logic             avalid_reg;
        logic [OUT_W-1:0] out_reg;
        logic [OFF_W-1:0] off_reg;
        logic             q_inc, out_dec;

        assign q_full[gi] = (q_reg == 4'hF);
        assign q_nz[gi]   = (q_reg != 4'h0);
        assign out_nz[gi] = (out_reg != '0);
        assign avalid[gi] = avalid_reg;
        assign a_hs[gi]   = avalid_reg & addr_ready[gi];
        assign off_v[gi]  = off_reg;
        assign q_inc      = gen_req[gi] & ~q_full[gi];
        assign out_dec    = done_evt[gi] & out_nz[gi];

        always_ff @(posedge fabric_clk or negedge fabric_rst_n) begin
            if (!fabric_rst_n) begin
                q_reg      <= '0;
                avalid_reg <= 1'b0;
                out_reg    <= '0;
                off_reg    <= '0;
            end else begin
                case ({q_inc, a_hs[gi]})
                    2'b10:   q_reg <= q_reg + 4'd1;
                    2'b01:   q_reg <= q_reg - 4'd1;
                    default: ;
                endcase
                case ({a_hs[gi], out_dec})
                    2'b10:   out_reg <= out_reg + 1'b1;
                    2'b01:   out_reg <= out_reg - 1'b1;
                    default: ;
                endcase
                // Issue only from idle so each address costs a fresh look at queue and credit.
                if (avalid_reg) begin
                    if (addr_ready[gi]) avalid_reg <= 1'b0;
                end else if (q_nz[gi] && (out_reg < OUT_MAX)) begin
                    avalid_reg <= 1'b1;
                end
                if (a_hs[gi]) off_reg <= off_reg + BURST_STEP;
            end
        end
    end

    logic [OUT_W:0]      w_owed_reg;
    logic [BEAT_W-1:0]   w_beat_reg;
    logic [OFF_W-1:0]    w_off_reg;
    logic [31:0]         wr_done_reg, rd_done_reg;
    logic [15:0]         err_cnt_reg;

    assign w_hs      = m_axi.wvalid & m_axi.wready;
    assign w_last_hs = w_hs & m_axi.wlast;

    always_ff @(posedge fabric_clk or negedge fabric_rst_n) begin
        if (!fabric_rst_n) begin
            w_owed_reg <= '0;
            w_beat_reg <= '0;
            w_off_reg  <= '0;
        end else begin
            case ({a_hs[0], w_last_hs})
                2'b10:   w_owed_reg <= w_owed_reg + 1'b1;
                2'b01:   w_owed_reg <= w_owed_reg - 1'b1;
                default: ;
            endcase
            if (w_hs) begin
                w_beat_reg <= (w_beat_reg == LAST_BEAT) ? '0 : w_beat_reg + 1'b1;
                w_off_reg  <= w_off_reg + BEAT_STEP;
            end
        end
    end

    // W beats are contiguous in window order, so a running beat offset addresses the pattern.
    for (genvar gi = 0; gi < LANES; gi++) begin : g_wlane
        assign m_axi.wdata[gi*32 +: 32] = (32'(w_off_reg) + 32'(gi * 4)) ^ PATTERN_SEED;
    end

    logic chk_err;
    logic unused_ok;

`ifdef RDATA_CHECK_EN
    logic [OFF_W-1:0]  rd_chk_off_reg;
    logic [BEAT_W-1:0] rd_beat_reg;
    logic [OFF_W-1:0]  rd_beat_off;
    logic [LANES-1:0]  lane_bad;

    always_ff @(posedge fabric_clk or negedge fabric_rst_n) begin
        if (!fabric_rst_n) begin
            rd_chk_off_reg <= '0;
            rd_beat_reg    <= '0;
        end else if (m_axi.rvalid) begin
            rd_beat_reg <= m_axi.rlast ? '0 : rd_beat_reg + 1'b1;
            if (m_axi.rlast) rd_chk_off_reg <= rd_chk_off_reg + BURST_STEP;
        end
    end

    assign rd_beat_off = rd_chk_off_reg + OFF_W'(32'(rd_beat_reg) * 32'(DATA_BYTES));

    for (genvar gi = 0; gi < LANES; gi++) begin : g_rlane
        assign lane_bad[gi] = m_axi.rdata[gi*32 +: 32] !=
                              ((32'(rd_beat_off) + 32'(gi * 4)) ^ PATTERN_SEED);
    end

    assign chk_err   = m_axi.rvalid & (|lane_bad);
    assign unused_ok = ^{m_axi.bid, m_axi.rid, TCQ};
`else
    assign chk_err   = 1'b0;
    assign unused_ok = ^{m_axi.bid, m_axi.rid, m_axi.rdata, TCQ};
`endif

    logic [1:0]  err_inc;
    logic [16:0] err_sum;

    assign err_inc = {1'b0, m_axi.bvalid & (m_axi.bresp != 2'b00)}
                   + {1'b0, m_axi.rvalid & (m_axi.rresp != 2'b00)}
                   + {1'b0, chk_err};
    assign err_sum = {1'b0, err_cnt_reg} + {15'b0, err_inc};

    always_ff @(posedge fabric_clk or negedge fabric_rst_n) begin
        if (!fabric_rst_n) begin
            wr_done_reg <= '0;
            rd_done_reg <= '0;
            err_cnt_reg <= '0;
        end else begin
            if (m_axi.bvalid) wr_done_reg <= wr_done_reg + 32'd1;
            if (r_last_evt)   rd_done_reg <= rd_done_reg + 32'd1;
            err_cnt_reg <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
        end
    end

    assign wr_req_rdy  = ~q_full[0];
    assign rd_req_rdy  = ~q_full[1];
    assign wr_done_cnt = wr_done_reg;
    assign rd_done_cnt = rd_done_reg;
    assign err_cnt     = err_cnt_reg;
    assign busy        = (|q_nz) | (|out_nz) | (|avalid) | (w_owed_reg != '0);

    assign m_axi.awaddr  = AXIBAR_ADDR + ADDR_WIDTH'(off_v[0]);
    assign m_axi.awlen   = 8'(BURST_LEN - 1);
    assign m_axi.awsize  = 3'($clog2(DATA_BYTES));
    assign m_axi.awburst = 2'b01;
    assign m_axi.awid    = 2'b00;
    assign m_axi.awlock  = 1'b0;
    assign m_axi.awcache = 4'b0000;
    assign m_axi.awprot  = 3'b000;
    assign m_axi.awvalid = avalid[0];
    assign m_axi.wstrb   = '1;
    assign m_axi.wlast   = (w_beat_reg == LAST_BEAT);
    assign m_axi.wvalid  = (w_owed_reg != '0);
    assign m_axi.bready  = 1'b1;
    assign m_axi.araddr  = AXIBAR_ADDR + ADDR_WIDTH'(off_v[1]);
    assign m_axi.arlen   = 8'(BURST_LEN - 1);
    assign m_axi.arsize  = 3'($clog2(DATA_BYTES));
    assign m_axi.arburst = 2'b01;
    assign m_axi.arid    = 2'b00;
    assign m_axi.arlock  = 1'b0;
    assign m_axi.arcache = 4'b0000;
    assign m_axi.arprot  = 3'b000;
    assign m_axi.arvalid = avalid[1];
    assign m_axi.rready  = 1'b1;
endmodule

// File: tb/tb_slave_bridge_burst_tg.sv
// Directed bench for slave_bridge_burst_tg: 512-bit bus, 4-beat bursts, 1 KiB window.
`timescale 1ns/1ps
module tb_slave_bridge_burst_tg;
    localparam int          DW    = 512;
    localparam int          AW    = 64;
    localparam logic [63:0] BASE  = 64'h0000_0008_0000_0000;
    localparam int          RANGE = 'h400;
    localparam logic [31:0] SEED  = 32'hA5A5_0000;

    logic        fabric_clk = 1'b0;
    logic        fabric_rst_n = 1'b0;
    logic        gen_wr = 1'b0, gen_rd = 1'b0;
    logic        wr_req_rdy, rd_req_rdy, busy;
    logic [31:0] wr_done_cnt, rd_done_cnt;
    logic [15:0] err_cnt;

    slave_bridge_burst_tg_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) m_if ();

    slave_bridge_burst_tg #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AXIBAR_ADDR(BASE), .ADDR_RANGE(RANGE),
        .BURST_LEN(4), .MAX_OUTSTANDING(8), .PATTERN_SEED(SEED)
    ) dut (
        .fabric_clk(fabric_clk), .fabric_rst_n(fabric_rst_n),
        .gen_wr(gen_wr), .gen_rd(gen_rd),
        .wr_req_rdy(wr_req_rdy), .rd_req_rdy(rd_req_rdy),
        .m_axi(m_if),
        .wr_done_cnt(wr_done_cnt), .rd_done_cnt(rd_done_cnt),
        .err_cnt(err_cnt), .busy(busy)
    );

    always #5 fabric_clk = ~fabric_clk;

    // Slave side: automatic responders plus manual overrides for error injection.
    logic          awready_s = 1'b1, wready_s = 1'b1, arready_s = 1'b1;
    logic          b_auto = 1'b0, r_auto = 1'b0, corrupt_en = 1'b0;
    logic          auto_bvalid, auto_rvalid, auto_rlast;
    logic [DW-1:0] auto_rdata;
    logic          man_bvalid = 1'b0, man_rvalid = 1'b0;
    logic [1:0]    man_bresp = 2'b00, man_rresp = 2'b00;
    logic [DW-1:0] man_rdata = '0;

    assign m_if.awready = awready_s;
    assign m_if.wready  = wready_s;
    assign m_if.arready = arready_s;
    assign m_if.bvalid  = auto_bvalid | man_bvalid;
    assign m_if.bresp   = man_bresp;
    assign m_if.bid     = 2'b00;
    assign m_if.rvalid  = auto_rvalid | man_rvalid;
    assign m_if.rdata   = man_rvalid ? man_rdata : auto_rdata;
    assign m_if.rresp   = man_rresp;
    assign m_if.rid     = 2'b00;
    assign m_if.rlast   = auto_rlast;

    int n_cmp = 0, n_bad = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge fabric_clk);
            #1;
        end
    endtask

    function automatic logic [DW-1:0] pattern(input int unsigned off);
        logic [DW-1:0] p;
        for (int l = 0; l < DW / 32; l++) p[l*32 +: 32] = (off + 32'(l * 4)) ^ SEED;
        return p;
    endfunction

    // Monitor: handshakes sampled mid-cycle complete on the next rising edge.
    int          aw_cnt = 0, ar_cnt = 0, w_cnt = 0, wlast_cnt = 0, out_now = 0, out_max = 0;
    logic [63:0] aw_addr [64];
    logic [63:0] ar_addr [64];
    logic [31:0] w_l0 [64];
    logic [31:0] w_l15 [64];
    logic        w_lst [64];

    always @(negedge fabric_clk) begin
        if (fabric_rst_n) begin
            if (m_if.awvalid && m_if.awready) begin
                if (aw_cnt < 64) aw_addr[aw_cnt] = m_if.awaddr;
                $display("AW #%0d addr=0x%0h", aw_cnt, m_if.awaddr);
                aw_cnt++;
                out_now++;
            end
            if (m_if.bvalid && out_now > 0) out_now--;
            if (out_now > out_max) out_max = out_now;
            if (m_if.wvalid && m_if.wready) begin
                if (w_cnt < 64) begin
                    w_l0[w_cnt]  = m_if.wdata[31:0];
                    w_l15[w_cnt] = m_if.wdata[511:480];
                    w_lst[w_cnt] = m_if.wlast;
                end
                if (m_if.wlast) wlast_cnt++;
                w_cnt++;
            end
            if (m_if.arvalid && m_if.arready) begin
                if (ar_cnt < 64) ar_addr[ar_cnt] = m_if.araddr;
                $display("AR #%0d addr=0x%0h", ar_cnt, m_if.araddr);
                ar_cnt++;
            end
        end
    end

    int b_sent = 0, r_sent = 0;

    initial begin
        auto_bvalid = 1'b0;
        forever begin
            @(posedge fabric_clk);
            #1;
            if (b_auto && wlast_cnt > b_sent) begin
                auto_bvalid = 1'b1;
                b_sent++;
            end else begin
                auto_bvalid = 1'b0;
            end
        end
    end

    initial begin
        auto_rvalid = 1'b0;
        auto_rlast  = 1'b0;
        auto_rdata  = '0;
        forever begin
            @(posedge fabric_clk);
            #1;
            if (r_auto && ar_cnt > r_sent) begin
                for (int b = 0; b < 4; b++) begin
                    auto_rvalid = 1'b1;
                    auto_rlast  = (b == 3);
                    auto_rdata  = pattern((r_sent * 256 + b * 64) % RANGE);
                    if (corrupt_en && r_sent == 0 && b == 2)
                        auto_rdata[3*32 +: 32] = ~auto_rdata[3*32 +: 32];
                    @(posedge fabric_clk);
                    #1;
                end
                auto_rvalid = 1'b0;
                auto_rlast  = 1'b0;
                r_sent++;
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    int exp_err = 0;

    initial begin
        tick(3);
        fabric_rst_n = 1'b1;
        tick(1);

        check_val("rst_awvalid", m_if.awvalid, 0);
        check_val("rst_wvalid", m_if.wvalid, 0);
        check_val("rst_arvalid", m_if.arvalid, 0);
        check_val("rst_wr_req_rdy", wr_req_rdy, 1);
        check_val("rst_rd_req_rdy", rd_req_rdy, 1);
        check_val("rst_busy", busy, 0);
        check_val("rst_wr_done", wr_done_cnt, 0);
        check_val("rst_err", err_cnt, 0);
        check_val("static_awlen", m_if.awlen, 3);
        check_val("static_awsize", m_if.awsize, 6);
        check_val("static_awburst", m_if.awburst, 1);
        check_val("static_wstrb", m_if.wstrb, 64'hFFFF_FFFF_FFFF_FFFF);
        check_val("static_bready", {m_if.bready, m_if.rready}, 2'b11);

        // Single write burst
        b_auto = 1'b1;
        gen_wr = 1'b1;
        tick(1);
        gen_wr = 1'b0;
        check_val("t1_busy_inflight", busy, 1);
        for (int i = 0; i < 50 && wr_done_cnt != 1; i++) tick(1);
        check_val("t1_aw_cnt", aw_cnt, 1);
        check_val("t1_awaddr", aw_addr[0], BASE);
        check_val("t1_w_beats", w_cnt, 4);
        check_val("t1_wlast_beat3", w_lst[3], 1);
        check_val("t1_wlast_beat2", w_lst[2], 0);
        check_val("t1_data_b0_l0", w_l0[0], SEED);
        check_val("t1_data_b1_l0", w_l0[1], SEED ^ 32'h40);
        check_val("t1_data_b0_l15", w_l15[0], SEED ^ 32'h3C);
        check_val("t1_wr_done", wr_done_cnt, 1);
        check_val("t1_busy_idle", busy, 0);

        // Queue overflow and outstanding limit
        b_auto = 1'b0;
        awready_s = 1'b0;
        gen_wr = 1'b1;
        tick(20);
        gen_wr = 1'b0;
        check_val("t2_wr_req_full", wr_req_rdy, 0);
        check_val("t2_no_aw_blocked", aw_cnt, 1);
        awready_s = 1'b1;
        tick(60);
        check_val("t2_aw_at_limit", aw_cnt, 9);
        check_val("t2_out_max", out_max, 8);
        check_val("t2_aw_stalled", m_if.awvalid, 0);
        check_val("t2_wr_req_rdy", wr_req_rdy, 1);
        b_auto = 1'b1;
        for (int i = 0; i < 600 && !(aw_cnt == 16 && wr_done_cnt == 16); i++) tick(1);
        check_val("t2_aw_total", aw_cnt, 16);
        check_val("t2_wr_done", wr_done_cnt, 16);
        check_val("t2_out_max_final", out_max, 8);
        check_val("t2_w_total", w_cnt, 64);
        check_val("t2_wlast_total", wlast_cnt, 16);
        check_val("t3_awaddr1", aw_addr[1], BASE + 64'h100);
        check_val("t3_awaddr4_wrap", aw_addr[4], BASE);
        check_val("t3_awaddr15", aw_addr[15], BASE + 64'h300);
        check_val("t3_data_wrap", w_l0[16], SEED);
        check_val("t3_data_b6_l15", w_l15[6], SEED ^ 32'h1BC);
        check_val("t3_data_b63_l0", w_l0[63], SEED ^ 32'h3C0);
        check_val("t2_busy_idle", busy, 0);

        // Read back four bursts
`ifdef RDATA_CHECK_EN
        corrupt_en = 1'b1;
        exp_err = 1;
`else
        corrupt_en = 1'b0;
        exp_err = 0;
`endif
        r_auto = 1'b1;
        gen_rd = 1'b1;
        tick(4);
        gen_rd = 1'b0;
        for (int i = 0; i < 300 && rd_done_cnt != 4; i++) tick(1);
        check_val("t4_rd_done", rd_done_cnt, 4);
        check_val("t4_ar_cnt", ar_cnt, 4);
        check_val("t4_araddr0", ar_addr[0], BASE);
        check_val("t4_araddr3", ar_addr[3], BASE + 64'h300);
        check_val("t4_err", err_cnt, exp_err);
        check_val("t4_busy_idle", busy, 0);

        // Error responses and saturation
        r_auto = 1'b0;
        b_auto = 1'b0;
        tick(2);
        man_bvalid = 1'b1;
        man_bresp  = 2'b10;
        man_rvalid = 1'b1;
        man_rresp  = 2'b11;
        man_rdata  = pattern(0);
        tick(1);
        man_rvalid = 1'b0;
        man_rresp  = 2'b00;
        exp_err = exp_err + 2;
        check_val("t5_dual_err", err_cnt, exp_err);
        for (int i = exp_err; i < 'hFFFE; i++) tick(1);
        man_bvalid = 1'b0;
        tick(1);
        check_val("t5_err_fffe", err_cnt, 16'hFFFE);
        man_bvalid = 1'b1;
        man_rvalid = 1'b1;
        man_rresp  = 2'b11;
        man_rdata  = pattern(64);
        tick(1);
        man_rvalid = 1'b0;
        man_rresp  = 2'b00;
        check_val("t5_err_saturate", err_cnt, 16'hFFFF);
        tick(1);
        check_val("t5_err_hold", err_cnt, 16'hFFFF);
        man_bvalid = 1'b0;
        man_bresp  = 2'b00;

        // Asynchronous reset in the middle of a W burst
        b_auto = 1'b1;
        wready_s = 1'b0;
        arready_s = 1'b0;
        gen_wr = 1'b1;
        gen_rd = 1'b1;
        tick(1);
        gen_wr = 1'b0;
        gen_rd = 1'b0;
        for (int i = 0; i < 20 && !(m_if.wvalid && m_if.arvalid); i++) tick(1);
        check_val("t6_pending", {m_if.wvalid, m_if.arvalid}, 2'b11);
        wready_s = 1'b1;
        tick(2);
        check_val("t6_mid_burst", m_if.wvalid, 1);
        #2;
        fabric_rst_n = 1'b0;
        #1;
        check_val("t6_wvalid_drop", m_if.wvalid, 0);
        check_val("t6_arvalid_drop", m_if.arvalid, 0);
        check_val("t6_awvalid_drop", m_if.awvalid, 0);
        check_val("t6_busy", busy, 0);
        check_val("t6_wr_done", wr_done_cnt, 0);
        check_val("t6_rd_done", rd_done_cnt, 0);
        check_val("t6_err", err_cnt, 0);
        check_val("t6_rd_req_rdy", rd_req_rdy, 1);
        tick(1);
        fabric_rst_n = 1'b1;
        tick(3);
        check_val("t6_post_busy", busy, 0);
        check_val("t6_post_wvalid", m_if.wvalid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
